// File: rtl/lsz.sv
// Least-significant-zero detector: one-hot and binary index of the lowest 0 bit of iGrey (LSZ_NOZERO_FLAG_EN adds oNoZero).
// Latency: one clock; every output is registered and loads the scan of iGrey sampled at each rising edge.
// Backpressure: none; a new word is accepted every cycle with no enable or handshake.
module lsz #(
    parameter  int BITWIDTH    = 4,
    localparam int LOGBITWIDTH = $clog2(BITWIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BITWIDTH-1:0]    iGrey,
    output logic [BITWIDTH-1:0]    oOneHot,
`ifdef LSZ_NOZERO_FLAG_EN
    output logic [LOGBITWIDTH-1:0] lszIdx,
    output logic                   oNoZero
`else
    output logic [LOGBITWIDTH-1:0] lszIdx
`endif
);

    logic [BITWIDTH-1:0]    zero_bit;
    logic [BITWIDTH-1:0]    found;
    logic [BITWIDTH-1:0]    hot_nxt;
    logic [LOGBITWIDTH-1:0] idx_nxt;

    assign zero_bit = ~iGrey;

    // found[i] is set when some bit below i is already zero, so bit i loses priority.
    for (genvar i = 0; i < BITWIDTH; i++) begin : g_chain
        if (i == 0) begin : g_first
            assign found[i] = 1'b0;
        end else begin : g_rest
            assign found[i] = found[i-1] | zero_bit[i-1];
        end
        assign hot_nxt[i] = zero_bit[i] & ~found[i];
    end

    // hot_nxt has at most one bit set, so OR-ing the indices is an exact encode.
    always_comb begin
        idx_nxt = '0;
        for (int i = 0; i < BITWIDTH; i++) begin
            if (hot_nxt[i]) begin
                idx_nxt = idx_nxt | LOGBITWIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oOneHot <= '0;
            lszIdx  <= '0;
        end else begin
            oOneHot <= hot_nxt;
            lszIdx  <= idx_nxt;
        end
    end

`ifdef LSZ_NOZERO_FLAG_EN
    logic no_zero_nxt;

    assign no_zero_nxt = ~(found[BITWIDTH-1] | zero_bit[BITWIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            oNoZero <= 1'b0;
        end else begin
            oNoZero <= no_zero_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_lsz.sv
// Bench for lsz: vector table, counter sweep with mid-stream reset, width variants and random stimulus vs a reference model.
module tb_lsz;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] g4  = '0;
    logic [7:0] g8  = '0;
    logic [4:0] g5  = '0;
    logic [3:0] hot4;
    logic [1:0] idx4;
    logic [7:0] hot8;
    logic [2:0] idx8;
    logic [4:0] hot5;
    logic [2:0] idx5;
`ifdef LSZ_NOZERO_FLAG_EN
    logic nz4, nz8, nz5;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

`ifdef LSZ_NOZERO_FLAG_EN
    lsz #(.BITWIDTH(4)) u4 (.clk(clk), .rst(rst), .iGrey(g4), .oOneHot(hot4), .lszIdx(idx4), .oNoZero(nz4));
    lsz #(.BITWIDTH(8)) u8 (.clk(clk), .rst(rst), .iGrey(g8), .oOneHot(hot8), .lszIdx(idx8), .oNoZero(nz8));
    lsz #(.BITWIDTH(5)) u5 (.clk(clk), .rst(rst), .iGrey(g5), .oOneHot(hot5), .lszIdx(idx5), .oNoZero(nz5));
`else
    lsz #(.BITWIDTH(4)) u4 (.clk(clk), .rst(rst), .iGrey(g4), .oOneHot(hot4), .lszIdx(idx4));
    lsz #(.BITWIDTH(8)) u8 (.clk(clk), .rst(rst), .iGrey(g8), .oOneHot(hot8), .lszIdx(idx8));
    lsz #(.BITWIDTH(5)) u5 (.clk(clk), .rst(rst), .iGrey(g5), .oOneHot(hot5), .lszIdx(idx5));
`endif

    typedef struct {
        logic       rst;
        logic [3:0] grey;
        logic [3:0] hot;
        logic [1:0] idx;
        logic       nz;
    } vec_t;

    vec_t tbl[10];
    int   seq[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive happens #1 after an edge; sampling happens #1 after the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Position of the lowest zero bit, or w when the word has no zero.
    function automatic int first_zero(input int v, input int w);
        int k = 0;
        while (k < w && ((v >> k) & 1) == 1) k++;
        return k;
    endfunction

    function automatic int ref_idx(input int v, input int w);
        int k = first_zero(v, w);
        return (k == w) ? 0 : k;
    endfunction

    function automatic int ref_hot(input int v, input int w);
        int k = first_zero(v, w);
        return (k == w) ? 0 : (1 << k);
    endfunction

    function automatic int ref_nz(input int v, input int w);
        return (first_zero(v, w) == w) ? 1 : 0;
    endfunction

    task automatic check_all(input string tag, input logic r, input int v4, input int v8, input int v5);
        check({tag, "_hot4"}, 32'(hot4), r ? 0 : ref_hot(v4, 4));
        check({tag, "_idx4"}, 32'(idx4), r ? 0 : ref_idx(v4, 4));
        check({tag, "_hot8"}, 32'(hot8), r ? 0 : ref_hot(v8, 8));
        check({tag, "_idx8"}, 32'(idx8), r ? 0 : ref_idx(v8, 8));
        check({tag, "_hot5"}, 32'(hot5), r ? 0 : ref_hot(v5, 5));
        check({tag, "_idx5"}, 32'(idx5), r ? 0 : ref_idx(v5, 5));
`ifdef LSZ_NOZERO_FLAG_EN
        check({tag, "_nz4"}, 32'(nz4), r ? 0 : ref_nz(v4, 4));
        check({tag, "_nz8"}, 32'(nz8), r ? 0 : ref_nz(v8, 8));
        check({tag, "_nz5"}, 32'(nz5), r ? 0 : ref_nz(v5, 5));
`endif
        check({tag, "_inv4"}, 32'(hot4 == 4'b0 || hot4 == (4'b1 << idx4)), 1);
        check({tag, "_inv8"}, 32'(hot8 == 8'b0 || hot8 == (8'b1 << idx8)), 1);
        check({tag, "_inv5"}, 32'(hot5 == 5'b0 || hot5 == (5'b1 << idx5)), 1);
    endtask

    initial begin
        int  prev;
        int  p4, p8, p5;
        logic pr;

        tbl[0] = '{1'b1, 4'b0110, 4'b0000, 2'd0, 1'b0};
        tbl[1] = '{1'b1, 4'b0110, 4'b0000, 2'd0, 1'b0};
        tbl[2] = '{1'b0, 4'b0110, 4'b0001, 2'd0, 1'b0};
        tbl[3] = '{1'b0, 4'b0000, 4'b0001, 2'd0, 1'b0};
        tbl[4] = '{1'b0, 4'b0101, 4'b0010, 2'd1, 1'b0};
        tbl[5] = '{1'b0, 4'b1011, 4'b0100, 2'd2, 1'b0};
        tbl[6] = '{1'b0, 4'b0111, 4'b1000, 2'd3, 1'b0};
        tbl[7] = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b1};
        tbl[8] = '{1'b0, 4'b1110, 4'b0001, 2'd0, 1'b0};
        tbl[9] = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b1};
        seq = '{0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0, 0};

        #1;
        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst;
            g4  = tbl[i].grey;
            step();
            check($sformatf("tbl%0d_hot", i), 32'(hot4), 32'(tbl[i].hot));
            check($sformatf("tbl%0d_idx", i), 32'(idx4), 32'(tbl[i].idx));
`ifdef LSZ_NOZERO_FLAG_EN
            check($sformatf("tbl%0d_nz", i), 32'(nz4), 32'(tbl[i].nz));
`endif
        end

        // Width variants at the top bit.
        g8 = 8'b0111_1111;
        g5 = 5'b01111;
        step();
        check("w8_hot", 32'(hot8), 32'h80);
        check("w8_idx", 32'(idx8), 7);
        check("w5_hot", 32'(hot5), 32'h10);
        check("w5_idx", 32'(idx5), 4);

        // Counter sweep with wrap at 16, including a mid-stream reset.
        g4 = 4'd0;
        for (int i = 0; i < 500; i++) begin
            if (i == 250) begin
                g4  = 4'b0011;
                rst = 1'b1;
                step();
                check("mid_rst_hot", 32'(hot4), 0);
                check("mid_rst_idx", 32'(idx4), 0);
                rst = 1'b0;
                step();
                check("post_rst_hot", 32'(hot4), 32'h4);
                check("post_rst_idx", 32'(idx4), 2);
            end
            prev = int'(g4);
            step();
            check($sformatf("sweep%0d_hot", i), 32'(hot4), ref_hot(prev, 4));
            check($sformatf("sweep%0d_seq", i), 32'(idx4), seq[prev]);
            check($sformatf("sweep%0d_inv", i), 32'(hot4 == 4'b0 || hot4 == (4'b1 << idx4)), 1);
            g4 = 4'((prev + 1) & 15);
        end

        // Random words on all widths with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            pr  = ($urandom_range(15) == 0);
            p4  = ($urandom_range(3) == 0) ? 15 : int'($urandom_range(15));
            p8  = ($urandom_range(3) == 0) ? 255 - (1 << $urandom_range(7)) : int'($urandom_range(255));
            p5  = ($urandom_range(3) == 0) ? 31 : int'($urandom_range(31));
            rst = pr;
            g4  = 4'(p4);
            g8  = 8'(p8);
            g5  = 5'(p5);
            step();
            check_all($sformatf("rnd%0d", i), pr, p4, p8, p5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
